alu_wb_tracker: RTL and testbench

Writeback tracker that sits directly downstream of the 4-stage vector ALU. It runs a tag pipeline alongside the ALU, so every accepted issue lines up with the ALU result that comes out ALU_LATENCY cycles later. Each aligned result is captured into a show-ahead result FIFO and presented to the register-file writer with a valid/ready handshake. A credit check on the issue port guarantees that no in-flight result can ever be lost when the writer stalls.

---
 rtl/alu_wb_tracker.sv | 154 +++++++++++++++
 tb/tb_alu_wb_tracker.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_tracker.sv
// Writeback tracker for the 4-stage vector ALU: tag pipeline, result FIFO,
// and issue credit so no in-flight result is lost while the writer stalls.
module alu_wb_tracker #(
    parameter int LANE_WIDTH  = 32,
    parameter int NUM_LANES   = 4,
    parameter int TAG_WIDTH   = 6,
    parameter int ALU_LATENCY = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [TAG_WIDTH-1:0]            issue_tag,
    input  logic [4:0]                      issue_op,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] alu_result_vec,
    input  logic [LANE_WIDTH-1:0]           alu_result_scalar,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [TAG_WIDTH-1:0]            wb_tag,
    output logic [NUM_LANES*LANE_WIDTH-1:0] wb_data,
    output logic [NUM_LANES-1:0]            wb_mask,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);

    localparam int DW  = NUM_LANES * LANE_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int IW  = $clog2(ALU_LATENCY + 1);
    localparam int SW  = CW + IW;
    localparam int LST = ALU_LATENCY - 1;

    logic                 w_fire;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic [DW-1:0]        w_cap_data;
    logic [NUM_LANES-1:0] w_cap_mask;
    logic [IW-1:0]        w_inflight;
    logic [SW-1:0]        w_used;

    logic [ALU_LATENCY-1:0] r_vld;
    logic [TAG_WIDTH-1:0]   r_tag [ALU_LATENCY];
    logic [4:0]             r_op  [ALU_LATENCY];

    logic [TAG_WIDTH-1:0] r_mem_tag  [FIFO_DEPTH];
    logic [DW-1:0]        r_mem_data [FIFO_DEPTH];
    logic [NUM_LANES-1:0] r_mem_mask [FIFO_DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ALU_LATENCY; i++) begin
            w_inflight = w_inflight + IW'(r_vld[i]);
        end
    end

    // Credit counts both queued and in-flight results, so a push always has room.
    assign w_used      = SW'(r_count) + SW'(w_inflight);
    assign issue_ready = w_used < SW'(FIFO_DEPTH);
    assign w_fire      = issue_valid & issue_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                r_tag[i] <= '0;
                r_op[i]  <= '0;
            end
        end else begin
            r_vld[0] <= w_fire;
            r_tag[0] <= issue_tag;
            r_op[0]  <= issue_op;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
                r_op[i]  <= r_op[i-1];
            end
        end
    end

    always_comb begin
        w_push_req = 1'b0;
        w_cap_data = '0;
        w_cap_mask = '0;
        if (r_vld[LST]) begin
            unique case (r_op[LST])
                5'b00001, 5'b00010, 5'b00011,
                5'b00100, 5'b00101: begin
                    w_push_req = 1'b1;
                    w_cap_data = alu_result_vec;
                    w_cap_mask = '1;
                end
                5'b10001: begin
                    w_push_req = 1'b1;
                    w_cap_data = DW'(alu_result_scalar);
                    w_cap_mask = NUM_LANES'(1);
                end
                5'b10010: begin
                    w_push_req = 1'b1;
                    w_cap_data = DW'(alu_result_vec[LANE_WIDTH-1:0]);
                    w_cap_mask = NUM_LANES'(1);
                end
                default: begin
                    w_push_req = 1'b0;
                end
            endcase
        end
    end

    assign w_full = r_count == CW'(FIFO_DEPTH);
    assign w_pop  = wb_valid & wb_ready;
    assign w_push = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_tag[r_wr]  <= r_tag[LST];
            r_mem_data[r_wr] <= w_cap_data;
            r_mem_mask[r_wr] <= w_cap_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Head fields are gated so stale or uninitialised entries never leak out.
    assign wb_valid   = r_count != '0;
    assign wb_tag     = wb_valid ? r_mem_tag[r_rd]  : '0;
    assign wb_data    = wb_valid ? r_mem_data[r_rd] : '0;
    assign wb_mask    = wb_valid ? r_mem_mask[r_rd] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_alu_wb_tracker.sv
// Directed bench for alu_wb_tracker with a behavioural 4-cycle ALU model
// feeding the result ports.
module tb_alu_wb_tracker;

    localparam int LW  = 32;
    localparam int NL  = 4;
    localparam int TW  = 6;
    localparam int LAT = 4;
    localparam int FD  = 8;
    localparam int DW  = NL * LW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_ready;
    logic [TW-1:0] issue_tag;
    logic [4:0]    issue_op;
    logic [DW-1:0] alu_result_vec;
    logic [LW-1:0] alu_result_scalar;
    logic          wb_valid;
    logic          wb_ready;
    logic [TW-1:0] wb_tag;
    logic [DW-1:0] wb_data;
    logic [NL-1:0] wb_mask;
    logic [3:0]    fifo_count;
    logic          overflow;

    logic [DW-1:0] tb_a;
    logic [DW-1:0] tb_b;
    logic [DW-1:0] p_vec;
    logic [LW-1:0] p_sc;
    logic [DW-1:0] m_vec [LAT];
    logic [LW-1:0] m_sc  [LAT];

    int n_vec;
    int n_bad;

    always #5 clk = ~clk;

    alu_wb_tracker #(
        .LANE_WIDTH (LW),
        .NUM_LANES  (NL),
        .TAG_WIDTH  (TW),
        .ALU_LATENCY(LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_tag        (issue_tag),
        .issue_op         (issue_op),
        .alu_result_vec   (alu_result_vec),
        .alu_result_scalar(alu_result_scalar),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_tag           (wb_tag),
        .wb_data          (wb_data),
        .wb_mask          (wb_mask),
        .fifo_count       (fifo_count),
        .overflow         (overflow)
    );

    task automatic alu_model(
        input  logic [4:0]    op,
        input  logic [DW-1:0] a,
        input  logic [DW-1:0] b,
        output logic [DW-1:0] v,
        output logic [LW-1:0] s
    );
        logic [LW-1:0] x;
        logic [LW-1:0] y;
        v = '0;
        s = (op == 5'd17) ? 32'd0 : 32'hBADC0DE5;
        for (int l = 0; l < NL; l++) begin
            x = a[l*LW +: LW];
            y = b[l*LW +: LW];
            case (op)
                5'd1:    v[l*LW +: LW] = x + y;
                5'd2:    v[l*LW +: LW] = x - y;
                5'd3:    v[l*LW +: LW] = x & y;
                5'd4:    v[l*LW +: LW] = x | y;
                5'd5:    v[l*LW +: LW] = x ^ y;
                5'd17:   v[l*LW +: LW] = 32'hDEADBEEF;
                5'd18:   v[l*LW +: LW] = x;
                default: v[l*LW +: LW] = x + y;
            endcase
            if (op == 5'd17) s = s + x * y;
        end
    endtask

    // ALU model: sample the issue mid-cycle, then a LAT-deep result delay line.
    always begin
        @(negedge clk);
        #3;
        if (issue_valid && issue_ready) begin
            alu_model(issue_op, tb_a, tb_b, p_vec, p_sc);
        end else begin
            p_vec = {4{32'hDEADBEEF}};
            p_sc  = 32'hBADC0DE5;
        end
    end

    always @(posedge clk) begin
        m_vec[0] <= p_vec;
        m_sc[0]  <= p_sc;
        for (int i = 1; i < LAT; i++) begin
            m_vec[i] <= m_vec[i-1];
            m_sc[i]  <= m_sc[i-1];
        end
    end

    assign alu_result_vec    = m_vec[LAT-1];
    assign alu_result_scalar = m_sc[LAT-1];

    task automatic issue_one(
        input logic [TW-1:0] tag,
        input logic [4:0]    op,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        @(negedge clk);
        issue_valid = 1'b1;
        issue_tag   = tag;
        issue_op    = op;
        tb_a        = a;
        tb_b        = b;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (wb_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid);
        end
        n_vec++;
        if (wb_tag !== '0) begin
            n_bad++; $display("FAIL rst_wb_tag: got %h want 0", wb_tag);
        end
        n_vec++;
        if (wb_data !== '0) begin
            n_bad++; $display("FAIL rst_wb_data: got %h want 0", wb_data);
        end
        n_vec++;
        if (wb_mask !== '0) begin
            n_bad++; $display("FAIL rst_wb_mask: got %b want 0", wb_mask);
        end
        n_vec++;
        if (fifo_count !== 4'd0) begin
            n_bad++; $display("FAIL rst_count: got %0d want 0", fifo_count);
        end
        n_vec++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL rst_overflow: got %b want 0", overflow);
        end
        n_vec++;
        if (issue_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_issue_ready: got %b want 1", issue_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        wb_ready    = 1'b1;
        issue_valid = 1'b1;
        issue_tag   = 6'd5;
        issue_op    = 5'd1;
        tb_a        = {32'd4, 32'd3, 32'd2, 32'd1};
        tb_b        = {4{32'd1}};
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) issue_valid = 1'b0;
            n_vec++;
            if (wb_valid !== 1'(c == 5)) begin
                n_bad++;
                $display("FAIL add_valid c%0d: got %b want %b", c, wb_valid, c == 5);
            end
            if (c == 5) begin
                n_vec++;
                if (wb_tag !== 6'd5) begin
                    n_bad++; $display("FAIL add_tag: got %0d want 5", wb_tag);
                end
                n_vec++;
                if (wb_data !== {32'd5, 32'd4, 32'd3, 32'd2}) begin
                    n_bad++; $display("FAIL add_data: got %h", wb_data);
                end
                n_vec++;
                if (wb_mask !== 4'hF) begin
                    n_bad++; $display("FAIL add_mask: got %b want 1111", wb_mask);
                end
                n_vec++;
                if (fifo_count !== 4'd1) begin
                    n_bad++; $display("FAIL add_count5: got %0d want 1", fifo_count);
                end
            end
        end
        n_vec++;
        if (fifo_count !== 4'd0) begin
            n_bad++; $display("FAIL add_count_end: got %0d want 0", fifo_count);
        end
    endtask

    task automatic test_dot4();
        wb_ready = 1'b1;
        issue_one(6'd9, 5'd17, {32'd1, 32'd2, 32'd3, 32'd4},
                  {32'd5, 32'd6, 32'd7, 32'd8});
        n_vec++;
        if (wb_valid !== 1'b1) begin
            n_bad++; $display("FAIL dot_valid: got %b want 1", wb_valid);
        end
        n_vec++;
        if (wb_tag !== 6'd9) begin
            n_bad++; $display("FAIL dot_tag: got %0d want 9", wb_tag);
        end
        n_vec++;
        if (wb_data !== DW'(70)) begin
            n_bad++; $display("FAIL dot_data: got %h want 70", wb_data);
        end
        n_vec++;
        if (wb_mask !== 4'b0001) begin
            n_bad++; $display("FAIL dot_mask: got %b want 0001", wb_mask);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rsqrt();
        wb_ready = 1'b1;
        issue_one(6'd12, 5'd18, {32'd40, 32'd30, 32'd20, 32'd10}, '0);
        n_vec++;
        if (wb_tag !== 6'd12) begin
            n_bad++; $display("FAIL rsq_tag: got %0d want 12", wb_tag);
        end
        n_vec++;
        if (wb_data !== DW'(10)) begin
            n_bad++; $display("FAIL rsq_data: got %h want 10", wb_data);
        end
        n_vec++;
        if (wb_mask !== 4'b0001) begin
            n_bad++; $display("FAIL rsq_mask: got %b want 0001", wb_mask);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int nacc;
        nacc     = 0;
        wb_ready = 1'b0;
        issue_op = 5'd1;
        tb_b     = {4{32'd1}};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_vec++;
            if (issue_ready !== 1'(c < 8)) begin
                n_bad++;
                $display("FAIL bp_ready c%0d: got %b want %b", c, issue_ready, c < 8);
            end
            issue_valid = 1'b1;
            issue_tag   = 6'(nacc);
            tb_a        = {4{32'(nacc)}};
            if (issue_ready) nacc++;
        end
        n_vec++;
        if (nacc != 8) begin
            n_bad++; $display("FAIL bp_accepted: got %0d want 8", nacc);
        end
        n_vec++;
        if (fifo_count !== 4'd8) begin
            n_bad++; $display("FAIL bp_count: got %0d want 8", fifo_count);
        end
        n_vec++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL bp_overflow: got %b want 0", overflow);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        wb_ready    = 1'b1;
        n_vec++;
        if (issue_ready !== 1'b0) begin
            n_bad++; $display("FAIL drain_ready0: got %b want 0", issue_ready);
        end
        n_vec++;
        if (wb_tag !== 6'd0 || wb_data !== {4{32'd1}}) begin
            n_bad++; $display("FAIL drain_head0: got %0d %h", wb_tag, wb_data);
        end
        for (int d = 1; d <= 8; d++) begin
            @(negedge clk);
            if (d == 1) begin
                n_vec++;
                if (issue_ready !== 1'b1) begin
                    n_bad++; $display("FAIL drain_ready1: got %b want 1", issue_ready);
                end
            end
            n_vec++;
            if (d < 8) begin
                if (wb_valid !== 1'b1 || wb_tag !== 6'(d) ||
                    wb_data !== {4{32'(d + 1)}}) begin
                    n_bad++;
                    $display("FAIL drain_pop%0d: got v%b tag %0d %h want tag %0d",
                             d, wb_valid, wb_tag, wb_data, d);
                end
            end else if (wb_valid !== 1'b0) begin
                n_bad++; $display("FAIL drain_empty: got %b want 0", wb_valid);
            end
        end
    endtask

    task automatic test_illegal();
        wb_ready = 1'b1;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_tag   = 6'd1;
        issue_op    = 5'd4;
        tb_a        = {4{32'hF0F0_0000}};
        tb_b        = {4{32'h0000_1234}};
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (wb_valid !== 1'(c == 5 || c == 7)) begin
                n_bad++; $display("FAIL ill_valid c%0d: got %b", c, wb_valid);
            end
            if (c == 5) begin
                n_vec++;
                if (wb_tag !== 6'd1 || wb_data !== {4{32'hF0F0_1234}}) begin
                    n_bad++; $display("FAIL ill_first: got %0d %h want 1", wb_tag, wb_data);
                end
            end
            if (c == 7) begin
                n_vec++;
                if (wb_tag !== 6'd2 || wb_data !== {4{32'h0F00_00FF}}) begin
                    n_bad++; $display("FAIL ill_second: got %0d %h want 2", wb_tag, wb_data);
                end
            end
            if (c == 1) begin
                issue_tag = 6'd3;
                issue_op  = 5'b00111;
            end else if (c == 2) begin
                issue_tag = 6'd2;
                issue_op  = 5'd4;
                tb_a      = {4{32'h0000_00FF}};
                tb_b      = {4{32'h0F00_0000}};
            end else if (c == 3) begin
                issue_valid = 1'b0;
            end
        end
    endtask

    task automatic test_alternate();
        int q[$];
        int sent;
        int got;
        int s;
        logic rdy;
        sent     = 0;
        got      = 0;
        issue_op = 5'd1;
        tb_b     = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int c = 0; c < 300 && (sent < 20 || q.size() > 0); c++) begin
            @(negedge clk);
            n_vec++;
            if (fifo_count > 4'd8 || overflow !== 1'b0) begin
                n_bad++;
                $display("FAIL alt_state c%0d: got count %0d ovf %b want <=8 0",
                         c, fifo_count, overflow);
            end
            rdy = 1'(c % 2);
            if (wb_valid && rdy) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL alt_extra: got tag %0d want none", wb_tag);
                end else begin
                    s = q.pop_front();
                    if (wb_tag !== 6'(s + 20) ||
                        wb_data !== {32'(s*3+4), 32'(s*3+3), 32'(s*3+2), 32'(s*3+1)}) begin
                        n_bad++;
                        $display("FAIL alt_pop: got %0d %h want tag %0d", wb_tag, wb_data, s + 20);
                    end
                    got++;
                end
            end
            wb_ready = rdy;
            if (sent < 20) begin
                issue_valid = 1'b1;
                issue_tag   = 6'(sent + 20);
                tb_a        = {4{32'(sent * 3)}};
                if (issue_ready) begin
                    q.push_back(sent);
                    sent++;
                end
            end else begin
                issue_valid = 1'b0;
            end
        end
        issue_valid = 1'b0;
        n_vec++;
        if (got != 20 || q.size() != 0) begin
            n_bad++; $display("FAIL alt_total: got %0d want 20", got);
        end
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b1;
        issue_op = 5'd1;
        tb_b     = {4{32'd1}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue_valid = 1'b1;
            issue_tag   = 6'(7 + i);
            tb_a        = {4{32'(i)}};
        end
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (wb_valid !== 1'b1 || wb_tag !== 6'd7) begin
            n_bad++; $display("FAIL rm_pre: got v%b tag %0d want 1 7", wb_valid, wb_tag);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (wb_valid !== 1'b0 || wb_tag !== '0 || wb_data !== '0 || wb_mask !== '0) begin
            n_bad++; $display("FAIL rm_wb: got v%b tag %0d m%b want 0", wb_valid, wb_tag, wb_mask);
        end
        n_vec++;
        if (fifo_count !== 4'd0 || overflow !== 1'b0 || issue_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_state: got cnt %0d ovf %b rdy %b want 0 0 1",
                     fifo_count, overflow, issue_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++;
            if (wb_valid !== 1'b0 || fifo_count !== 4'd0) begin
                n_bad++;
                $display("FAIL rm_after c%0d: got v%b cnt %0d want 0", c, wb_valid, fifo_count);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        issue_op    = '0;
        tb_a        = '0;
        tb_b        = '0;
        wb_ready    = 1'b0;
        n_vec       = 0;
        n_bad       = 0;
        test_reset();
        test_single_add();
        test_dot4();
        test_rsqrt();
        test_backpressure();
        test_illegal();
        test_alternate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
